// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Brief    : Single-port memory arbiter between instruction fetch and data
//            access, with bounded fetch starvation under data pressure.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ifReq,
  input  logic [AW-1:0] ifAddr,
  input  logic          dReq,
  input  logic          dWe,
  input  logic [AW-1:0] dAddr,
  input  logic [DW-1:0] dWdata,
  input  logic          memReady,
  input  logic [DW-1:0] memRdata,
  output logic          memReq,
  output logic          memWe,
  output logic [AW-1:0] memAddr,
  output logic [DW-1:0] memWdata,
  output logic [DW-1:0] ifRdata,
  output logic          ifValid,
  output logic [DW-1:0] dRdata,
  output logic          dValid,
  output logic          memstall
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    D_BUSY  = 2'd2
  } state_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_e        state_q, state_d;
  logic [3:0]    starve_q, starve_d;
  logic          grant_d, grant_if;

  logic          memWe_q;
  logic [AW-1:0] memAddr_q;
  logic [DW-1:0] memWdata_q;
  logic [DW-1:0] ifRdata_q;
  logic [DW-1:0] dRdata_q;
  logic          ifValid_q;
  logic          dValid_q;

  // Data normally wins, except when a waiting fetch has already been passed
  // over STARVE_MAX times in a row.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    grant_d  = 1'b0;
    grant_if = 1'b0;
    case (state_q)
      IDLE: begin
        if (dReq && !(ifReq && (starve_q == STARVE_LIM))) begin
          grant_d = 1'b1;
          state_d = D_BUSY;
          if (ifReq) begin
            starve_d = (starve_q < STARVE_LIM) ? starve_q + 4'd1 : STARVE_LIM;
          end else begin
            starve_d = 4'd0;
          end
        end else if (ifReq) begin
          grant_if = 1'b1;
          state_d  = IF_BUSY;
          starve_d = 4'd0;
        end
      end
      IF_BUSY, D_BUSY: begin
        if (memReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      starve_q   <= 4'd0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      ifRdata_q  <= '0;
      dRdata_q   <= '0;
      ifValid_q  <= 1'b0;
      dValid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      ifValid_q <= 1'b0;
      dValid_q  <= 1'b0;
      if (grant_d) begin
        memAddr_q  <= dAddr;
        memWe_q    <= dWe;
        memWdata_q <= dWdata;
      end else if (grant_if) begin
        memAddr_q <= ifAddr;
        memWe_q   <= 1'b0;
      end
      if ((state_q == IF_BUSY) && memReady) begin
        ifRdata_q <= memRdata;
        ifValid_q <= 1'b1;
      end
      // Stores complete with a pulse only; the load result register is kept.
      if ((state_q == D_BUSY) && memReady) begin
        dValid_q <= 1'b1;
        if (!memWe_q) dRdata_q <= memRdata;
      end
    end
  end

  assign memReq   = (state_q != IDLE);
  assign memWe    = memWe_q;
  assign memAddr  = memAddr_q;
  assign memWdata = memWdata_q;
  assign ifRdata  = ifRdata_q;
  assign ifValid  = ifValid_q;
  assign dRdata   = dRdata_q;
  assign dValid   = dValid_q;
  assign memstall = (ifReq & ~ifValid_q) | (dReq & ~dValid_q);

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed self-checking bench for mem_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        ifReq;
  logic [31:0] ifAddr;
  logic        dReq;
  logic        dWe;
  logic [31:0] dAddr;
  logic [31:0] dWdata;
  logic        memReady;
  logic [31:0] memRdata;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic [31:0] ifRdata;
  logic        ifValid;
  logic [31:0] dRdata;
  logic        dValid;
  logic        memstall;

  int n_checks;
  int n_fail;

  mem_arbiter #(.AW(32), .DW(32), .STARVE_MAX(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ifReq    (ifReq),
    .ifAddr   (ifAddr),
    .dReq     (dReq),
    .dWe      (dWe),
    .dAddr    (dAddr),
    .dWdata   (dWdata),
    .memReady (memReady),
    .memRdata (memRdata),
    .memReq   (memReq),
    .memWe    (memWe),
    .memAddr  (memAddr),
    .memWdata (memWdata),
    .ifRdata  (ifRdata),
    .ifValid  (ifValid),
    .dRdata   (dRdata),
    .dValid   (dValid),
    .memstall (memstall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({memReq, memWe, ifValid, dValid, memstall} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {memReq, memWe, ifValid, dValid, memstall});
    end
    n_checks++;
    if ({memAddr, memWdata, ifRdata, dRdata} !== 128'h0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", {memAddr, memWdata, ifRdata, dRdata});
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (memReq !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: memReq got %b expected 0", memReq);
    end
  endtask

  task automatic test_fetch();
    ifReq = 1'b1; ifAddr = 32'h100;
    tick();
    n_checks++;
    if ({memReq, memWe, memAddr} !== {1'b1, 1'b0, 32'h100}) begin
      n_fail++; $display("FAIL fetch_grant: got req=%b we=%b addr=%h expected 1 0 00000100", memReq, memWe, memAddr);
    end
    tick();
    n_checks++;
    if ({memReq, memWe, ifValid} !== 3'b100) begin
      n_fail++; $display("FAIL fetch_wait: got req/we/valid=%b expected 100", {memReq, memWe, ifValid});
    end
    memReady = 1'b1; memRdata = 32'h2408000A;
    tick();
    n_checks++;
    if ({ifValid, dValid, memReq, ifRdata} !== {3'b100, 32'h2408000A}) begin
      n_fail++; $display("FAIL fetch_done: got v=%b dv=%b req=%b data=%h expected 1 0 0 2408000a", ifValid, dValid, memReq, ifRdata);
    end
    ifReq = 1'b0; memReady = 1'b0;
    tick();
    n_checks++;
    if ({ifValid, memReq, ifRdata} !== {2'b00, 32'h2408000A}) begin
      n_fail++; $display("FAIL fetch_after: got v=%b req=%b data=%h expected 0 0 2408000a", ifValid, memReq, ifRdata);
    end
  endtask

  task automatic test_store();
    dReq = 1'b1; dWe = 1'b1; dAddr = 32'h40; dWdata = 32'hDEADBEEF;
    tick();
    n_checks++;
    if ({memReq, memWe, memAddr, memWdata} !== {2'b11, 32'h40, 32'hDEADBEEF}) begin
      n_fail++; $display("FAIL store_grant: got req=%b we=%b addr=%h wd=%h expected 1 1 00000040 deadbeef", memReq, memWe, memAddr, memWdata);
    end
    memReady = 1'b1; memRdata = 32'h12345678;
    tick();
    n_checks++;
    if ({dValid, ifValid, memReq, dRdata} !== {3'b100, 32'h0}) begin
      n_fail++; $display("FAIL store_done: got dv=%b iv=%b req=%b rdata=%h expected 1 0 0 00000000", dValid, ifValid, memReq, dRdata);
    end
    dReq = 1'b0; dWe = 1'b0; memReady = 1'b0;
    tick();
    n_checks++;
    if ({dValid, memReq} !== 2'b00) begin
      n_fail++; $display("FAIL store_after: got dv/req=%b expected 00", {dValid, memReq});
    end
  endtask

  task automatic test_stall();
    dReq = 1'b1; dWe = 1'b0; dAddr = 32'h80; dWdata = 32'h0;
    #1;
    n_checks++;
    if (memstall !== 1'b1) begin
      n_fail++; $display("FAIL stall_pre: memstall got %b expected 1", memstall);
    end
    tick();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({memReq, memstall, memWe, dValid} !== 4'b1100) begin
        n_fail++; $display("FAIL stall_cycle%0d: got req/stall/we/dv=%b expected 1100", i, {memReq, memstall, memWe, dValid});
      end
      if (i == 4) begin
        memReady = 1'b1; memRdata = 32'hCAFEF00D;
      end
      tick();
    end
    n_checks++;
    if ({dValid, memstall, memReq, dRdata} !== {3'b100, 32'hCAFEF00D}) begin
      n_fail++; $display("FAIL stall_done: got dv=%b stall=%b req=%b rdata=%h expected 1 0 0 cafef00d", dValid, memstall, memReq, dRdata);
    end
    dReq = 1'b0; memReady = 1'b0;
    tick();
  endtask

  task automatic test_contention();
    // Expected grant order with STARVE_MAX=3: D, D, D, IF, D
    logic [4:0] is_fetch;
    is_fetch = 5'b01000;
    ifReq = 1'b1; ifAddr = 32'h200;
    dReq = 1'b1; dWe = 1'b0; dAddr = 32'h300;
    memReady = 1'b1;
    for (int k = 0; k < 5; k++) begin
      memRdata = 32'h1000 + k;
      tick();
      n_checks++;
      if ({memReq, memAddr} !== {1'b1, (is_fetch[k] ? 32'h200 : 32'h300)}) begin
        n_fail++; $display("FAIL contend_grant%0d: got req=%b addr=%h expected 1 %h", k, memReq, memAddr, (is_fetch[k] ? 32'h200 : 32'h300));
      end
      tick();
      n_checks++;
      if ({ifValid, dValid} !== (is_fetch[k] ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL contend_valid%0d: got if/d valid=%b expected %b", k, {ifValid, dValid}, (is_fetch[k] ? 2'b10 : 2'b01));
      end
      if (k == 3) begin
        n_checks++;
        if ({dut.starve_q, ifRdata} !== {4'd0, 32'h1003}) begin
          n_fail++; $display("FAIL contend_starve: got cnt=%0d ifRdata=%h expected 0 00001003", dut.starve_q, ifRdata);
        end
      end
    end
    n_checks++;
    if ({dut.starve_q, dRdata} !== {4'd1, 32'h1004}) begin
      n_fail++; $display("FAIL contend_end: got cnt=%0d dRdata=%h expected 1 00001004", dut.starve_q, dRdata);
    end
    ifReq = 1'b0; dReq = 1'b0; memReady = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    dReq = 1'b1; dWe = 1'b1; dAddr = 32'h44; dWdata = 32'h55;
    tick();
    n_checks++;
    if (memReq !== 1'b1) begin
      n_fail++; $display("FAIL areset_busy: memReq got %b expected 1", memReq);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({memReq, memWe, memAddr, ifRdata, dRdata} !== {2'b00, 96'h0}) begin
      n_fail++; $display("FAIL areset_now: got req=%b we=%b addr=%h ifr=%h dr=%h expected all 0", memReq, memWe, memAddr, ifRdata, dRdata);
    end
    dReq = 1'b0; dWe = 1'b0; memReady = 1'b1;
    tick();
    n_checks++;
    if ({dValid, ifValid, memReq} !== 3'b000) begin
      n_fail++; $display("FAIL areset_novalid: got dv/iv/req=%b expected 000", {dValid, ifValid, memReq});
    end
    rst_n = 1'b1; memReady = 1'b0;
    ifReq = 1'b1; ifAddr = 32'h104;
    tick();
    n_checks++;
    if ({memReq, memAddr} !== {1'b1, 32'h104}) begin
      n_fail++; $display("FAIL areset_next: got req=%b addr=%h expected 1 00000104", memReq, memAddr);
    end
    memReady = 1'b1; memRdata = 32'h0BADC0DE;
    tick();
    n_checks++;
    if ({ifValid, ifRdata} !== {1'b1, 32'h0BADC0DE}) begin
      n_fail++; $display("FAIL areset_nextdone: got v=%b data=%h expected 1 0badc0de", ifValid, ifRdata);
    end
    ifReq = 1'b0; memReady = 1'b0;
    tick();
  endtask

  task automatic test_dropped();
    ifReq = 1'b1; ifAddr = 32'h108;
    tick();
    ifReq = 1'b0;
    tick();
    n_checks++;
    if ({memReq, memAddr, ifValid} !== {1'b1, 32'h108, 1'b0}) begin
      n_fail++; $display("FAIL drop_busy: got req=%b addr=%h v=%b expected 1 00000108 0", memReq, memAddr, ifValid);
    end
    memReady = 1'b1; memRdata = 32'h11112222;
    tick();
    n_checks++;
    if ({ifValid, memReq, ifRdata} !== {2'b10, 32'h11112222}) begin
      n_fail++; $display("FAIL drop_done: got v=%b req=%b data=%h expected 1 0 11112222", ifValid, memReq, ifRdata);
    end
    // memReady held high while idle must not produce any completion
    tick();
    n_checks++;
    if ({ifValid, dValid, memReq, memstall} !== 4'b0000) begin
      n_fail++; $display("FAIL idle_ready: got iv/dv/req/stall=%b expected 0000", {ifValid, dValid, memReq, memstall});
    end
    memReady = 1'b0;
    tick();
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0; ifReq = 1'b0; ifAddr = '0; dReq = 1'b0; dWe = 1'b0;
    dAddr = '0; dWdata = '0; memReady = 1'b0; memRdata = '0;
    test_reset();
    test_fetch();
    test_store();
    test_stall();
    test_contention();
    test_async_reset();
    test_dropped();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32: address width.
REQ-002 SHALL have parameter DW, default 32: data width.
REQ-003 SHALL have parameter STARVE_MAX, default 3: maximum consecutive data grants while a fetch waits; range 1..15.
REQ-004 SHALL have the following ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  reset; asynchronous and active-low.
- ifReq  input  1  instruction fetch request; level, held until ifValid.
- ifAddr  input  AW  fetch address.
- dReq  input  1  data request (load or store); level, held until dValid.
- dWe  input  1  1 = store, 0 = load.
- dAddr  input  AW  data address.
- dWdata  input  DW  store data.
- memReady  input  1  memory has completed the current access.
- memRdata  input  DW  memory read data; valid with memReady.
- memReq  output  1  access request to the single-port memory.
- memWe  output  1  write enable to memory.
- memAddr  output  AW  memory address.
- memWdata  output  DW  memory write data.
- ifRdata  output  DW  fetched instruction, registered.
- ifValid  output  1  one-cycle pulse; fetch complete.
- dRdata  output  DW  load data, registered.
- dValid  output  1  one-cycle pulse; data access complete.
- memstall  output  1  pipeline stall for the hazard logic.

Function
REQ-005 SHALL implement a three-state FSM: IDLE, IF_BUSY, D_BUSY.
REQ-006 In IDLE with dReq=1, SHALL go to D_BUSY unless ifReq=1 and starve_cnt==STARVE_MAX.
REQ-007 In IDLE, SHALL go to IF_BUSY when ifReq=1 and REQ-006 does not grant data.
REQ-008 In IDLE with neither request, SHALL remain in IDLE.
REQ-009 On a grant edge, SHALL register the following into memAddr/memWe/memWdata:
- data grant: dAddr, dWe, dWdata.
- fetch grant: ifAddr, memWe=0, memWdata unchanged.
REQ-010 SHALL drive memReq=1 exactly while in IF_BUSY or D_BUSY.
REQ-011 SHALL hold memAddr, memWe and memWdata stable throughout a busy state.
REQ-012 In a busy state, SHALL stay busy while memReady=0; there is no timeout.
REQ-013 In a busy state with memReady=1, on the next edge SHALL:
- capture memRdata into ifRdata (IF_BUSY) or dRdata (D_BUSY);
- pulse the matching valid for exactly one cycle;
- return to IDLE.
REQ-014 On a store completion, SHALL pulse dValid and leave dRdata unchanged.
REQ-015 ifRdata and dRdata SHALL hold their last captured value until the next completion of the same type.
REQ-016 SHALL ignore memReady while in IDLE.
REQ-017 Once a transaction is granted, SHALL complete it, even if the requester drops its request mid-transaction; the valid pulse is still issued.
REQ-018 Latency: request sampled in IDLE at edge N gives memReq=1 after edge N; memReady=1 before edge M gives valid=1 after edge M; minimum request-to-valid is 2 cycles.
REQ-019 The FSM SHALL spend at least one cycle in IDLE between transactions, so back-to-back memReq pulses are separated by one low cycle.
REQ-020 starve_cnt SHALL be a 4-bit register updated on each grant:
- data grant with ifReq=1: increment, saturating at STARVE_MAX;
- fetch grant: clear to 0;
- data grant with ifReq=0: clear to 0.
REQ-021 SHALL drive memstall combinationally: memstall = (ifReq & ~ifValid) | (dReq & ~dValid).
REQ-022 SHALL never assert ifValid and dValid in the same cycle.

Reset
REQ-023 On rst_n=0, SHALL immediately, without waiting for a clock edge:
- set the state to IDLE;
- set memReq, memWe, ifValid and dValid to 0;
- set memAddr, memWdata, ifRdata and dRdata to 0;
- set starve_cnt to 0.
REQ-024 When reset is asserted during a busy state, SHALL abandon the transaction, issue no valid pulse, and start normal operation on the first edge after rst_n rises.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Fetch only: ifReq=1, ifAddr=0x100, memReady one cycle after memReq with memRdata=0x2408000A -> ifValid pulse, ifRdata=0x2408000A, memWe=0 throughout.
- Store: dReq=1, dWe=1, dAddr=0x40, dWdata=0xDEADBEEF -> memWe=1, memAddr=0x40, memWdata=0xDEADBEEF while memReq=1; dValid pulse; dRdata unchanged.
- Contention with STARVE_MAX=3: ifReq and dReq held high with immediate memReady -> grant order D,D,D,IF, then starve_cnt=0.
- Stall timing: load with memReady delayed 5 cycles -> memstall=1 for every cycle until dValid, memReq continuously 1 for 5 cycles.
- Async reset: rst_n pulled low mid-D_BUSY between edges -> memReq=0 immediately, no dValid, next request served normally after release.
- Dropped request: ifReq deasserted in IF_BUSY -> transaction completes, ifValid still pulses, FSM returns to IDLE.
